// File: rtl/fir_interp2_if.sv
// Sample-in / sample-out bundle for the 2x interpolating FIR.
// Source drives din/din_valid; the filter returns ready and the output stream.
interface fir_interp2_if;
  logic signed [7:0] din;
  logic              din_valid;
  logic              din_ready;
  logic signed [7:0] dout;
  logic              dout_valid;
  logic              dout_odd;

  modport master (
    output din, din_valid,
    input  din_ready, dout, dout_valid, dout_odd
  );

  modport slave (
    input  din, din_valid,
    output din_ready, dout, dout_valid, dout_odd
  );
endinterface

// File: rtl/fir_interp2.sv
// 2x polyphase interpolating FIR, 13-tap symmetric kernel, even then odd phase.
// Define FIR_INTERP2_ROUND_EN for round-half-up before the output shift.
module fir_interp2 #(
  parameter int OUT_SHIFT = 8,
  parameter int SAT_MAX   = 127,
  parameter int SAT_MIN   = -127
) (
  input  logic          clk,
  input  logic          n_rst,
  fir_interp2_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    EVEN,
    ODD
  } state_e;

  localparam logic signed [7:0] CE [7] = '{
    -8'sd24, 8'sd0, 8'sd80, 8'sd127, 8'sd80, 8'sd0, -8'sd24
  };
  localparam logic signed [7:0] CO [7] = '{
    -8'sd21, 8'sd37, 8'sd114, 8'sd114, 8'sd37, -8'sd21, 8'sd0
  };

  state_e state_q, state_d;
  logic   ready_q, ready_d;
  logic   accept;

  logic signed [7:0]  x_q [7];
  logic signed [7:0]  x_d [7];
  logic signed [15:0] p_q [7];
  logic signed [15:0] p_d [7];
  logic               v1_q, v1_d;
  logic               odd1_q, odd1_d;

  logic signed [18:0] acc;
  logic signed [18:0] sh;
  logic signed [7:0]  sat;
  logic signed [7:0]  dout_q, dout_d;
  logic               dv_q, dv_d;
  logic               dodd_q, dodd_d;

  assign accept = bus.din_valid & ready_q;

  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      (state_q == IDLE): state_d = accept ? EVEN : IDLE;
      (state_q == EVEN): state_d = ODD;
      (state_q == ODD):  state_d = accept ? EVEN : IDLE;
      default:           state_d = IDLE;
    endcase
    ready_d = (state_d != EVEN);
  end

  always_comb begin
    for (int i = 0; i < 7; i++) x_d[i] = x_q[i];
    if (accept) begin
      x_d[0] = bus.din;
      for (int i = 1; i < 7; i++) x_d[i] = x_q[i-1];
    end
  end

  // Products latch the phase chosen by the state; the delay line is stable
  // through both phase cycles since the next accept lands at the end of ODD.
  always_comb begin
    v1_d   = (state_q == EVEN) || (state_q == ODD);
    odd1_d = (state_q == ODD);
    for (int i = 0; i < 7; i++) begin
      p_d[i] = p_q[i];
      if (v1_d)
        p_d[i] = 16'(x_q[i]) * 16'(odd1_d ? CO[i] : CE[i]);
    end
  end

  always_comb begin
    acc = '0;
    for (int i = 0; i < 7; i++) acc = acc + 19'(p_q[i]);
`ifdef FIR_INTERP2_ROUND_EN
    acc = acc + (19'sd1 <<< (OUT_SHIFT - 1));
`else
    acc = acc;
`endif
    sh = acc >>> OUT_SHIFT;
    if (sh > 19'(SAT_MAX))
      sat = 8'(SAT_MAX);
    else if (sh < 19'(SAT_MIN))
      sat = 8'(SAT_MIN);
    else
      sat = sh[7:0];
    dout_d = v1_q ? sat : dout_q;
    dv_d   = v1_q;
    dodd_d = v1_q ? odd1_q : dodd_q;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      ready_q <= 1'b1;
      for (int i = 0; i < 7; i++) begin
        x_q[i] <= '0;
        p_q[i] <= '0;
      end
      v1_q   <= 1'b0;
      odd1_q <= 1'b0;
      dout_q <= '0;
      dv_q   <= 1'b0;
      dodd_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      for (int i = 0; i < 7; i++) begin
        x_q[i] <= x_d[i];
        p_q[i] <= p_d[i];
      end
      v1_q   <= v1_d;
      odd1_q <= odd1_d;
      dout_q <= dout_d;
      dv_q   <= dv_d;
      dodd_q <= dodd_d;
    end
  end

  assign bus.din_ready  = ready_q;
  assign bus.dout       = dout_q;
  assign bus.dout_valid = dv_q;
  assign bus.dout_odd   = dodd_q;

endmodule

// File: tb/tb_fir_interp2.sv
// Directed bench for fir_interp2: impulse, DC, saturation, handshake, reset.
// Expected values are hand-derived from the kernel; FIR_INTERP2_ROUND_EN aware.
module tb_fir_interp2;

  logic clk;
  logic n_rst;
  fir_interp2_if bus ();

  fir_interp2 dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef FIR_INTERP2_ROUND_EN
  localparam int IMP [16] = '{
    -12, -10, 0, 18, 40, 57, 63, 57, 40, 18, 0, -10, -12, 0, 0, 0
  };
  localparam int DC_E  = 93;
  localparam int DC_O  = 102;
  localparam int SP_E  = 119;
  localparam int SN_E  = -119;
`else
  localparam int IMP [16] = '{
    -12, -11, 0, 18, 39, 56, 63, 56, 39, 18, 0, -11, -12, 0, 0, 0
  };
  localparam int DC_E  = 93;
  localparam int DC_O  = 101;
  localparam int SP_E  = 118;
  localparam int SN_E  = -120;
`endif
  localparam int SP_O = 127;
  localparam int SN_O = -127;

  int n_cmp;
  int n_bad;
  int outq [$];
  int oddq [$];

  always @(negedge clk) begin
    if (bus.dout_valid) begin
      outq.push_back(int'(bus.dout));
      oddq.push_back(int'(bus.dout_odd));
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic signed [7:0] v);
    bit done;
    done = 1'b0;
    bus.din       = v;
    bus.din_valid = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      done = bus.din_ready;
      tick();
    end
    if (!done) chk("push_timeout", 0, 1);
  endtask

  task automatic flush();
    bus.din_valid = 1'b0;
    repeat (6) tick();
  endtask

  task automatic clear_q();
    outq.delete();
    oddq.delete();
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_dout"}, int'(bus.dout), 0);
    chk({tag, "_vld"}, int'(bus.dout_valid), 0);
    chk({tag, "_odd"}, int'(bus.dout_odd), 0);
    chk({tag, "_rdy"}, int'(bus.din_ready), 1);
  endtask

  task automatic run_impulse(input string tag);
    clear_q();
    push(8'sd127);
    repeat (7) push(8'sd0);
    flush();
    chk({tag, "_cnt"}, outq.size(), 16);
    for (int i = 0; i < 16 && i < outq.size(); i++) begin
      chk($sformatf("%s_y%0d", tag, i), outq[i], IMP[i]);
      chk($sformatf("%s_ph%0d", tag, i), oddq[i], i % 2);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int er;
    int ev;
    n_cmp = 0;
    n_bad = 0;
    n_rst = 1'b0;
    bus.din = '0;
    bus.din_valid = 1'b0;
    repeat (3) tick();
    chk_reset("rst0");
    n_rst = 1'b1;
    tick();
    chk_reset("rst0_rel");

    run_impulse("imp");

    // DC stream, then a 3-cycle gap in din_valid
    clear_q();
    bus.din = 8'sd100;
    for (int k = 1; k <= 30; k++) begin
      bus.din_valid = !(k >= 21 && k <= 23);
      tick();
      if (k <= 20)      er = (k % 2 == 0);
      else if (k <= 23) er = 1;
      else              er = (k % 2 == 1);
      ev = ((k >= 3 && k <= 22) || k >= 26);
      chk($sformatf("hs_rdy%0d", k), int'(bus.din_ready), er);
      chk($sformatf("hs_vld%0d", k), int'(bus.dout_valid), ev);
      if (k == 19) begin
        chk("dc_even", int'(bus.dout), DC_E);
        chk("dc_even_ph", int'(bus.dout_odd), 0);
      end
      if (k == 20) begin
        chk("dc_odd", int'(bus.dout), DC_O);
        chk("dc_odd_ph", int'(bus.dout_odd), 1);
      end
      if (k == 24) chk("dc_hold", int'(bus.dout), DC_O);
    end
    flush();

    clear_q();
    repeat (8) push(8'sd127);
    flush();
    chk("satp_cnt", outq.size(), 16);
    if (outq.size() >= 16) begin
      chk("satp_even", outq[14], SP_E);
      chk("satp_odd", outq[15], SP_O);
    end

    // negative saturation, then reset with outputs still in flight
    clear_q();
    repeat (10) push(-8'sd128);
    chk("satn_cnt", outq.size(), 16);
    if (outq.size() >= 16) begin
      chk("satn_even", outq[14], SN_E);
      chk("satn_odd", outq[15], SN_O);
    end
    n_rst = 1'b0;
    bus.din_valid = 1'b0;
    #2;
    chk_reset("rst1");
    repeat (2) tick();
    n_rst = 1'b1;
    tick();
    chk_reset("rst1_rel");
    repeat (3) tick();
    chk("rst1_noout", int'(bus.dout_valid), 0);
    run_impulse("imp2");

    // din_valid pulsed while not ready must be ignored
    clear_q();
    push(8'sd0);
    chk("nr_rdy", int'(bus.din_ready), 0);
    bus.din = 8'sd77;
    bus.din_valid = 1'b1;
    tick();
    bus.din_valid = 1'b0;
    repeat (6) tick();
    chk("nr_cnt", outq.size(), 2);
    push(8'sd0);
    flush();
    chk("nr_cnt2", outq.size(), 4);
    if (outq.size() >= 4) begin
      chk("nr_even", outq[2], 0);
      chk("nr_odd", outq[3], 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
